mult_datapath: RTL and testbench

Shift-add multiplier datapath for the calculator's multiply function. It holds the multiplicand, the accumulator, the multiplier/low-product shift register and the bit counter. Its registers advance only under the one-hot Start/Add/Shift/Halt strobes from the multiplier control FSM, and it returns the Q0 (current multiplier LSB) and C0 (last bit) status bits to that FSM. The product is presented to the result mux on completion.

---
 rtl/mult_datapath_if.sv | 25 ++
 rtl/mult_datapath.sv | 95 +++++++++
 tb/tb_mult_datapath.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mult_datapath_if.sv
// Strobe, operand and status bundle between the multiplier control FSM and mult_datapath.
interface mult_datapath_if #(
    parameter int WIDTH = 8
);
    logic                   Start;
    logic                   Add;
    logic                   Shift;
    logic                   Halt;
    logic [WIDTH-1:0]       Multiplicand;
    logic [WIDTH-1:0]       Multiplier;
    logic                   Q0;
    logic                   C0;
    logic [2*WIDTH-1:0]     Product;
    logic                   Done;

    modport master (
        output Start, Add, Shift, Halt, Multiplicand, Multiplier,
        input  Q0, C0, Product, Done
    );

    modport slave (
        input  Start, Add, Shift, Halt, Multiplicand, Multiplier,
        output Q0, C0, Product, Done
    );
endinterface

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath (M, C:A:Q, bit counter) driven by one-hot control strobes.
// Optional product holding register and Done pulse: define MULT_PRODUCT_REG_EN.
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    mult_datapath_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] m_r, a_r, q_r;
    logic [WIDTH-1:0] m_s, a_s, q_s;
    logic             c_r, c_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH:0]   sum_s;

    assign sum_s = {1'b0, a_r} + {1'b0, m_r};

    // Next-state selection; strobe priority Start > Add > Shift, Halt and idle hold
    always_comb begin
        m_s   = m_r;
        a_s   = a_r;
        q_s   = q_r;
        c_s   = c_r;
        cnt_s = cnt_r;
        if (bus.Start) begin
            m_s   = bus.Multiplicand;
            q_s   = bus.Multiplier;
            a_s   = {WIDTH{1'b0}};
            c_s   = 1'b0;
            cnt_s = CNT_W'(WIDTH - 1);
        end else if (bus.Add) begin
            {c_s, a_s} = sum_s;
        end else if (bus.Shift) begin
            c_s   = 1'b0;
            a_s   = {c_r, a_r[WIDTH-1:1]};
            q_s   = {a_r[0], q_r[WIDTH-1:1]};
            cnt_s = (cnt_r == {CNT_W{1'b0}}) ? cnt_r : (cnt_r - CNT_W'(1));
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Datapath registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_r   <= {WIDTH{1'b0}};
            a_r   <= {WIDTH{1'b0}};
            q_r   <= {WIDTH{1'b0}};
            c_r   <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            m_r   <= m_s;
            a_r   <= a_s;
            q_r   <= q_s;
            c_r   <= c_s;
            cnt_r <= cnt_s;
        end
    end

    assign bus.Q0 = q_r[0];
    assign bus.C0 = (cnt_r == {CNT_W{1'b0}});

`ifdef MULT_PRODUCT_REG_EN
    logic                 halt_s;
    logic                 halt_d_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   prod_r;

    // Halt only counts when no higher-priority strobe accompanies it
    assign halt_s = bus.Halt & ~bus.Start & ~bus.Add & ~bus.Shift;

    // Capture the product on the first Halt cycle and pulse Done after it
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            halt_d_r <= 1'b0;
            done_r   <= 1'b0;
            prod_r   <= {(2*WIDTH){1'b0}};
        end else begin
            halt_d_r <= halt_s;
            done_r   <= halt_s & ~halt_d_r;
            if (halt_s && !halt_d_r) begin
                prod_r <= {a_r, q_r};
            end
        end
    end

    assign bus.Product = prod_r;
    assign bus.Done    = done_r;
`else
    assign bus.Product = {a_r, q_r};
    assign bus.Done    = bus.Halt;
`endif
endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench: plays the control FSM against WIDTH=8 and WIDTH=4 datapaths.
module tb_mult_datapath;
    logic        Clock;
    logic        Reset;
    int          nerr = 0;
    int          nchk = 0;

    logic        sel4, st, ad, sh, ha;
    logic [15:0] mc, mp;
    logic        q0_s, c0_s, done_s;
    logic [15:0] prod_s;
    logic [15:0] prev8, prev4;

    mult_datapath_if #(.WIDTH(8)) bus8 ();
    mult_datapath_if #(.WIDTH(4)) bus4 ();

    mult_datapath #(.WIDTH(8)) dut8 (.Clock(Clock), .Reset(Reset), .bus(bus8));
    mult_datapath #(.WIDTH(4)) dut4 (.Clock(Clock), .Reset(Reset), .bus(bus4));

    assign bus8.Start        = st & ~sel4;
    assign bus8.Add          = ad & ~sel4;
    assign bus8.Shift        = sh & ~sel4;
    assign bus8.Halt         = ha & ~sel4;
    assign bus8.Multiplicand = mc[7:0];
    assign bus8.Multiplier   = mp[7:0];
    assign bus4.Start        = st & sel4;
    assign bus4.Add          = ad & sel4;
    assign bus4.Shift        = sh & sel4;
    assign bus4.Halt         = ha & sel4;
    assign bus4.Multiplicand = mc[3:0];
    assign bus4.Multiplier   = mp[3:0];

    assign q0_s   = sel4 ? bus4.Q0   : bus8.Q0;
    assign c0_s   = sel4 ? bus4.C0   : bus8.C0;
    assign done_s = sel4 ? bus4.Done : bus8.Done;
    assign prod_s = sel4 ? {8'h00, bus4.Product} : bus8.Product;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q0"},   32'(q0_s),   32'd0);
        check({tag, "_c0"},   32'(c0_s),   32'd1);
        check({tag, "_prod"}, 32'(prod_s), 32'd0);
        check({tag, "_done"}, 32'(done_s), 32'd0);
    endtask

    // Acts as the control FSM: Start, then per bit Test/[Add]/Shift until C0, then Halt.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input bit collide);
        logic [31:0] exp_p;
        logic [15:0] prev;
        int          idx;
        int          shifts;
        bit          c0seen;
        bit          q0v;
        bit          c0v;
        exp_p  = 32'(a) * 32'(b);
        sel4   = (w == 4);
        prev   = sel4 ? prev4 : prev8;
        mc     = a;
        mp     = b;
        st     = 1'b1;
        ad     = collide;
        cyc();
        st     = 1'b0;
        ad     = 1'b0;
        mc     = 16'(~a);
        mp     = 16'(~b);
        #1;
        idx    = 1;
        check("start_q0",   32'(q0_s),   32'(b[0]));
        check("start_c0",   32'(c0_s),   32'd0);
        check("start_done", 32'(done_s), 32'd0);
`ifdef MULT_PRODUCT_REG_EN
        check("hold_prod",  32'(prod_s), 32'(prev));
`else
        check("start_prod", 32'(prod_s), 32'(b));
`endif
        shifts = 0;
        c0seen = 1'b0;
        for (int g = 0; g < w + 2 && !c0seen; g++) begin
            q0v = q0_s;
            cyc();
            idx++;
            if (q0v) begin
                ad = 1'b1;
                cyc();
                ad = 1'b0;
                idx++;
            end
            c0v = c0_s;
            check("c0_shift", 32'(c0v), 32'(shifts + 1 == w));
            sh = 1'b1;
            cyc();
            sh = 1'b0;
            shifts++;
            idx++;
            c0seen = c0v;
        end
        check("shift_count", 32'(shifts), 32'(w));
        ha = 1'b1;
        #1;
        check("latency", 32'(idx), 32'(1 + 2 * w + $countones(b)));
`ifndef MULT_PRODUCT_REG_EN
        check("halt_done", 32'(done_s), 32'd1);
        check("halt_prod", 32'(prod_s), exp_p);
`endif
        cyc();
        check("done_1",    32'(done_s), 32'd1);
        check("product",   32'(prod_s), exp_p);
        cyc();
`ifdef MULT_PRODUCT_REG_EN
        check("done_once", 32'(done_s), 32'd0);
`else
        check("done_lvl",  32'(done_s), 32'd1);
`endif
        check("prod_hold", 32'(prod_s), exp_p);
        ha = 1'b0;
        #1;
        if (sel4) prev4 = exp_p[15:0];
        else      prev8 = exp_p[15:0];
    endtask

    initial begin
        logic [15:0] ra, rb;
        Reset = 1'b0;
        sel4  = 1'b0;
        st = 1'b0; ad = 1'b0; sh = 1'b0; ha = 1'b0;
        mc = 16'h0000; mp = 16'h0000;
        prev8 = 16'h0000; prev4 = 16'h0000;
        #3;
        check_reset_outputs("rst8");
        sel4 = 1'b1;
        #1;
        check_reset_outputs("rst4");
        sel4 = 1'b0;
        #9;
        Reset = 1'b1;
        cyc();

        run_op(8, 16'd13,  16'd11,  1'b0);
        run_op(8, 16'd255, 16'd255, 1'b0);
        run_op(8, 16'd99,  16'd77,  1'b1);
        run_op(8, 16'd0,   16'd200, 1'b0);
        run_op(8, 16'd200, 16'd0,   1'b0);
        run_op(8, 16'd6,   16'd7,   1'b0);
        run_op(8, 16'd5,   16'd9,   1'b0);

        // Reset in the fifth cycle of a 99 x 77 operation
        sel4 = 1'b0;
        mc = 16'd99; mp = 16'd77;
        st = 1'b1; cyc(); st = 1'b0;
        cyc();
        ad = 1'b1; cyc(); ad = 1'b0;
        sh = 1'b1; cyc(); sh = 1'b0;
        cyc();
        #1;
        Reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        prev8 = 16'h0000;
        prev4 = 16'h0000;
        cyc();
        Reset = 1'b1;
        cyc();
        run_op(8, 16'd99, 16'd77, 1'b0);

        run_op(4, 16'd15, 16'd15, 1'b0);

        for (int i = 0; i < 5; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            run_op(8, ra, rb, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            ra = 16'($urandom_range(0, 15));
            rb = 16'($urandom_range(0, 15));
            run_op(4, ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
